// File: rtl/axi_read_arbiter.sv
// Two-master (inst/data cache) to one-slave AXI read arbiter with one burst outstanding.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise DATA_FIRST fixes the tie winner.
module axi_read_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [48:0] i_ar,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [38:0] i_r,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [48:0] d_ar,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [38:0] d_r,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [48:0] m_ar,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [38:0] m_r,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR_I = 3'd1,
    AR_D = 3'd2,
    R_I  = 3'd3,
    R_D  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [48:0] ar_q, ar_d;
  logic        grant_d_s;
  logic        rlast_s;

  assign rlast_s = m_r[0];

`ifdef ARB_RR_EN
  // last_grant_q: 1'b1 = data was granted last, 1'b0 = inst
  logic last_grant_q, last_grant_d;

  assign grant_d_s = d_arvalid && (!i_arvalid || !last_grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant_d_s = d_arvalid && (!i_arvalid || (DATA_FIRST == 1'b1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ar_q    <= 49'd0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
    end
  end

  // Outputs are gated off while rst is high so an abandoned burst sees no further handshakes.
  always_comb begin
    state_d   = state_q;
    ar_d      = ar_q;
    i_arready = 1'b0;
    d_arready = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (i_arvalid || d_arvalid) begin
`ifdef ARB_RR_EN
            last_grant_d = grant_d_s;
`endif
            if (grant_d_s) begin
              d_arready = 1'b1;
              ar_d      = d_ar;
              state_d   = AR_D;
            end else begin
              i_arready = 1'b1;
              ar_d      = i_ar;
              state_d   = AR_I;
            end
          end else begin
            state_d = IDLE;
          end
        end
        AR_I, AR_D: begin
          m_arvalid = 1'b1;
          if (m_arready) begin
            state_d = (state_q == AR_I) ? R_I : R_D;
          end else begin
            state_d = state_q;
          end
        end
        R_I: begin
          i_rvalid = m_rvalid;
          m_rready = i_rready;
          if (m_rvalid && i_rready && rlast_s) begin
            state_d = IDLE;
          end else begin
            state_d = R_I;
          end
        end
        R_D: begin
          d_rvalid = m_rvalid;
          m_rready = d_rready;
          if (m_rvalid && d_rready && rlast_s) begin
            state_d = IDLE;
          end else begin
            state_d = R_D;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  assign m_ar = ar_q;
  assign i_r  = m_r;
  assign d_r  = m_r;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: vector table plus AR/R scoreboards and burst sequences.
module tb_axi_read_arbiter;

  localparam logic [48:0] I_AR = {4'b0010, 32'h1FC0_0000, 8'd0, 3'd2, 2'd1};
  localparam logic [48:0] D_AR = {4'b0101, 32'h8000_1000, 8'd15, 3'd2, 2'd1};

  logic        clk, rst;
  logic [48:0] i_ar, d_ar, m_ar;
  logic        i_arvalid, i_arready, d_arvalid, d_arready;
  logic [38:0] i_r, d_r, m_r;
  logic        i_rvalid, i_rready, d_rvalid, d_rready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        rl;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [48:0] ar_sb[$];
  logic [32:0] r_sb[$];
  logic        last_m;

  typedef struct {
    logic [6:0]  in;    // {iv, dv, marr, mrv, mlast, irr, drr}
    logic [31:0] rdata;
    logic [5:0]  exp;   // {i_arready, d_arready, m_arvalid, m_rready, i_rvalid, d_rvalid}
    logic [48:0] ar;    // expected m_ar when m_arvalid
  } vec_t;

  vec_t vt[18];

  axi_read_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_ar(i_ar), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_r(i_r), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_ar(d_ar), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_r(d_r), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_ar(m_ar), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_r(m_r), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [6:0] in, input logic [31:0] rdata,
                              input logic [5:0] exp, input logic [48:0] ar);
    vec_t v;
    v.in = in; v.rdata = rdata; v.exp = exp; v.ar = ar;
    return v;
  endfunction

  function automatic logic tie_winner();
`ifdef ARB_RR_EN
    return !last_m;
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard side: pop expected AR/R items on each completed handshake
  always @(negedge clk) begin
    if (m_arvalid && m_arready) begin
      if (ar_sb.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
      else chk("m_ar", {15'd0, m_ar}, {15'd0, ar_sb.pop_front()});
    end
    if (i_rvalid && i_rready) begin
      if (r_sb.size() == 0) chk("i_beat_unexpected", 64'd1, 64'd0);
      else chk("i_beat", {31'd0, 1'b0, i_r[34:3]}, {31'd0, r_sb.pop_front()});
    end
    if (d_rvalid && d_rready) begin
      if (r_sb.size() == 0) chk("d_beat_unexpected", 64'd1, 64'd0);
      else chk("d_beat", {31'd0, 1'b1, d_r[34:3]}, {31'd0, r_sb.pop_front()});
    end
    if (!rst) begin
      chk("excl_rvalid", {63'd0, i_rvalid & d_rvalid}, 64'd0);
      chk("excl_arready", {63'd0, i_arready & d_arready}, 64'd0);
    end
  end

  task automatic grant(input logic to_d, input logic both);
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_arready = 1'b0;
    i_arvalid = !to_d || both;
    d_arvalid = to_d || both;
    ar_sb.push_back(to_d ? D_AR : I_AR);
    last_m = to_d;
    @(negedge clk);
    chk("grant_i", {63'd0, i_arready}, {63'd0, !to_d});
    chk("grant_d", {63'd0, d_arready}, {63'd0, to_d});
    @(posedge clk); #1;
    if (to_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    m_arready = 1'b1;
    @(negedge clk);
    chk("ar_valid", {63'd0, m_arvalid}, 64'd1);
    chk("ar_no_arready", {62'd0, i_arready, d_arready}, 64'd0);
  endtask

  task automatic run_r(input logic to_d, input int nbeats, input int total,
                       input int stall_at, input logic [31:0] base);
    int   k = 0;
    int   guard = 0;
    logic stall;
    logic stalled = 1'b0;
    while (k < nbeats && guard < 100) begin
      @(posedge clk); #1;
      m_arready = 1'b0;
      stall = (k == stall_at) && !stalled;
      m_rvalid = 1'b1;
      m_r = {4'h0, base + k, 2'b00, (k == total - 1)};
      if (to_d) begin d_rready = !stall; i_rready = 1'b1; end
      else begin i_rready = !stall; d_rready = 1'b1; end
      if (!stall) r_sb.push_back({to_d, base + k});
      @(negedge clk);
      chk("r_m_rready", {63'd0, m_rready}, {63'd0, !stall});
      chk("r_granted_rvalid", {63'd0, to_d ? d_rvalid : i_rvalid}, 64'd1);
      chk("r_other_rvalid", {63'd0, to_d ? i_rvalid : d_rvalid}, 64'd0);
      chk("r_no_arready", {62'd0, i_arready, d_arready}, 64'd0);
      if (stall) stalled = 1'b1; else k++;
      guard++;
    end
    if (guard >= 100) chk("r_budget", 64'd1, 64'd0);
  endtask

  task automatic tie_round(input int nb, input int stall_at, input logic [31:0] base);
    logic w;
    w = tie_winner();
    grant(w, 1'b1);
    run_r(w, nb, nb, stall_at, base);
    grant(!w, 1'b0);
    run_r(!w, 1, 1, -1, base + 32'h100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(7'b1000000, 32'h0,         6'b100000, 49'd0);
    vt[1]  = mk(7'b0010000, 32'h0,         6'b001000, I_AR);
    vt[2]  = mk(7'b0000010, 32'h0,         6'b000100, 49'd0);
    vt[3]  = mk(7'b0001110, 32'hDEADBEEF,  6'b000110, 49'd0);
    vt[4]  = mk(7'b0000000, 32'h0,         6'b000000, 49'd0);
    vt[5]  = mk(7'b0100000, 32'h0,         6'b010000, 49'd0);
    vt[6]  = mk(7'b1001000, 32'h1111,      6'b001000, D_AR);
    vt[7]  = mk(7'b1000000, 32'h0,         6'b001000, D_AR);
    vt[8]  = mk(7'b1000000, 32'h0,         6'b001000, D_AR);
    vt[9]  = mk(7'b1000000, 32'h0,         6'b001000, D_AR);
    vt[10] = mk(7'b1000000, 32'h0,         6'b001000, D_AR);
    vt[11] = mk(7'b1010000, 32'h0,         6'b001000, D_AR);
    vt[12] = mk(7'b1001101, 32'hCAFE0001,  6'b000101, 49'd0);
    vt[13] = mk(7'b1000000, 32'h0,         6'b100000, 49'd0);
    vt[14] = mk(7'b0010000, 32'h0,         6'b001000, I_AR);
    vt[15] = mk(7'b0001000, 32'h0BAD,      6'b000010, 49'd0);
    vt[16] = mk(7'b0001110, 32'h12345678,  6'b000110, 49'd0);
    vt[17] = mk(7'b0001100, 32'h5555,      6'b000000, 49'd0);

    i_ar = I_AR; d_ar = D_AR;
    rst = 1'b1; i_arvalid = 1'b1; d_arvalid = 1'b1; m_arready = 1'b1;
    m_rvalid = 1'b1; m_r = 39'd1; i_rready = 1'b1; d_rready = 1'b1;
    last_m = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", {58'd0, i_arready, d_arready, m_arvalid, m_rready, i_rvalid, d_rvalid}, 64'd0);
      chk("reset_m_ar", {15'd0, m_ar}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; i_arvalid = 1'b0; d_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b0; i_rready = 1'b0; d_rready = 1'b0;

    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      {i_arvalid, d_arvalid, m_arready, m_rvalid, rl, i_rready, d_rready} = vt[k].in;
      m_r = {4'h0, vt[k].rdata, 2'b00, rl};
      if (vt[k].exp[5]) begin ar_sb.push_back(I_AR); last_m = 1'b0; end
      if (vt[k].exp[4]) begin ar_sb.push_back(D_AR); last_m = 1'b1; end
      if (vt[k].exp[1] && i_rready) r_sb.push_back({1'b0, vt[k].rdata});
      if (vt[k].exp[0] && d_rready) r_sb.push_back({1'b1, vt[k].rdata});
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", k),
          {58'd0, i_arready, d_arready, m_arvalid, m_rready, i_rvalid, d_rvalid},
          {58'd0, vt[k].exp});
      if (vt[k].exp[3]) chk($sformatf("vec%0d_m_ar", k), {15'd0, m_ar}, {15'd0, vt[k].ar});
    end

    // Ties: 16-beat burst with a stall on beat 3, then a second tie
    tie_round(16, 2, 32'hA000_0000);
    tie_round(2, -1, 32'hB000_0000);

    // Reset during beat 5 of a data burst, then a fresh inst request
    grant(1'b1, 1'b0);
    run_r(1'b1, 4, 16, -1, 32'hC000_0000);
    @(posedge clk); #1;
    rst = 1'b1; m_rvalid = 1'b1; m_r = {4'h0, 32'hC000_0004, 2'b00, 1'b0};
    d_rready = 1'b1; i_arvalid = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {58'd0, i_arready, d_arready, m_arvalid, m_rready, i_rvalid, d_rvalid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ar_sb.push_back(I_AR); last_m = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {58'd0, i_arready, d_arready, m_arvalid, m_rready, i_rvalid, d_rvalid}, 64'd32);
    @(posedge clk); #1;
    i_arvalid = 1'b0; m_arready = 1'b1; m_rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_ar", {63'd0, m_arvalid}, 64'd1);
    run_r(1'b0, 1, 1, -1, 32'hD000_0000);

    @(posedge clk); #1;
    m_rvalid = 1'b0; i_rready = 1'b0; d_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_r_empty", r_sb.size(), 64'd0);
    chk("sb_ar_empty", ar_sb.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
